// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: two requesters share one immediate-extension unit.
// Round-robin grant, valid/ready on both sides, single registered result slot.
// Optional statistics counters are built when IMM_EXT_STATS_EN is defined.
module imm_ext_arbiter #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [IMM_W-1:0]  req_imm0,
    input  logic [IMM_W-1:0]  req_imm1,
    input  logic [1:0]        req_mode0,
    input  logic [1:0]        req_mode1,
    output logic [1:0]        req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // Elaboration-time parameter sanity checks
    if (DATA_W < IMM_W + 2) begin : g_bad_data_w
        $error("DATA_W must be at least IMM_W+2");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be nonzero");
    end

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   data_q;
    logic                id_q;
    logic                last_gnt_q;

    logic [1:0]          gnt;
    logic                can_accept;
    logic                xfer;
    logic                pop;
    logic                sel;
    logic [IMM_W-1:0]    sel_imm;
    logic [1:0]          sel_mode;
    logic [DATA_W-1:0]   sext;
    logic [DATA_W-1:0]   ext_data;

    assign out_valid  = (state_q == StFull);
    assign out_data   = data_q;
    assign out_id     = id_q;
    assign pop        = out_valid & out_ready;
    assign can_accept = ~out_valid | out_ready;
    // Nothing may be accepted while reset is asserted.
    assign req_ready  = gnt & {2{can_accept & rst_n}};
    assign xfer       = |(req_valid & req_ready);
    assign sel        = req_ready[1];

    // Round-robin grant: on contention the port that did not win last goes
    always_comb begin
        gnt = 2'b00;
        case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Select the granted operand and extend it according to its mode
    always_comb begin
        sel_imm  = sel ? req_imm1 : req_imm0;
        sel_mode = sel ? req_mode1 : req_mode0;
        sext     = {{(DATA_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
        ext_data = sext;
        case (sel_mode)
            2'b00:   ext_data = sext;
            2'b01:   ext_data = {{(DATA_W-IMM_W){1'b0}}, sel_imm};
            2'b10:   ext_data = {sel_imm, {(DATA_W-IMM_W){1'b0}}};
            2'b11:   ext_data = sext << 2;
            default: ext_data = sext;
        endcase
    end

    // Result-slot FSM; priority rotates only on a completed transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            data_q     <= '0;
            id_q       <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (xfer) begin
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (pop && !xfer) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
            if (xfer) begin
                data_q     <= ext_data;
                id_q       <= sel;
                last_gnt_q <= sel;
            end
        end
    end

`ifdef IMM_EXT_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0_q;
    logic [CNT_W-1:0] gnt_cnt1_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] cnt_one;

    assign cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    assign gnt_cnt0  = gnt_cnt0_q;
    assign gnt_cnt1  = gnt_cnt1_q;
    assign stall_cnt = stall_cnt_q;

    // Saturating per-port transfer and stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q  <= '0;
            gnt_cnt1_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer && !sel && gnt_cnt0_q != '1) begin
                gnt_cnt0_q <= gnt_cnt0_q + cnt_one;
            end
            if (xfer && sel && gnt_cnt1_q != '1) begin
                gnt_cnt1_q <= gnt_cnt1_q + cnt_one;
            end
            if ((|req_valid) && !xfer && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + cnt_one;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: stimulus pushes expected results,
// a monitor pops and compares on every accepted output beat.
module tb_imm_ext_arbiter;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [IMM_W-1:0]  req_imm0;
    logic [IMM_W-1:0]  req_imm1;
    logic [1:0]        req_mode0;
    logic [1:0]        req_mode1;
    logic [1:0]        req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_id;
`ifdef IMM_EXT_STATS_EN
    logic [CNT_W-1:0]  gnt_cnt0;
    logic [CNT_W-1:0]  gnt_cnt1;
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_data_q[$];
    logic              exp_id_q[$];

    imm_ext_arbiter #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_imm0  (req_imm0),
        .req_imm1  (req_imm1),
        .req_mode0 (req_mode0),
        .req_mode1 (req_mode1),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef IMM_EXT_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic id);
        exp_data_q.push_back(d);
        exp_id_q.push_back(id);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on a port and hold it until it transfers
    task automatic issue(input int port, input logic [IMM_W-1:0] imm, input logic [1:0] mode,
                         input logic [DATA_W-1:0] exp);
        bit done = 0;
        int n = 0;
        push(exp, port[0]);
        if (port == 0) begin
            req_imm0  = imm;
            req_mode0 = mode;
        end else begin
            req_imm1  = imm;
            req_mode1 = mode;
        end
        req_valid[port] = 1'b1;
        while (!done && n < 20) begin
            @(negedge clk);
            if (req_ready[port]) done = 1;
            step();
            n++;
        end
        req_valid[port] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout port=%0d got=no_ready expected=ready", port);
        end
    endtask

    // Monitor: compare every accepted output beat against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got=%0h/%0d expected=none", out_data, out_id);
                end else begin
                    logic [DATA_W-1:0] ed;
                    logic              ei;
                    ed = exp_data_q.pop_front();
                    ei = exp_id_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(ed));
                    chk("out_id", 64'(out_id), 64'(ei));
                end
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_imm0  = '0;
        req_imm1  = '0;
        req_mode0 = 2'b00;
        req_mode1 = 2'b00;
        out_ready = 1'b1;

        // Reset state, and no acceptance while in reset
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        step();
        rst_n = 1'b1;

        // Sign extension on port 0
        issue(0, 16'h8001, 2'b00, 32'hFFFF8001);

        // Remaining modes on port 1; 0xFFFFF00F << 2 truncated = 0xFFFFC03C
        issue(1, 16'hF00F, 2'b01, 32'h0000F00F);
        issue(1, 16'hF00F, 2'b10, 32'hF00F0000);
        issue(1, 16'hF00F, 2'b11, 32'hFFFFC03C);

        // Continuous contention: grants alternate starting with port 0
        req_imm0  = 16'h0001;
        req_mode0 = 2'b00;
        req_imm1  = 16'h8002;
        req_mode1 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(32'h00000001, 1'b0);
            else            push(32'h00008002, 1'b1);
        end
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_ready", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            step();
        end
        req_valid = 2'b00;
        step();

        // Back-pressure: result held, nobody accepted, then pop+fill together
        out_ready = 1'b0;
        issue(0, 16'h1234, 2'b01, 32'h00001234);
        req_imm1  = 16'h00AB;
        req_mode1 = 2'b00;
        push(32'h000000AB, 1'b1);
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_data", 64'(out_data), 64'h00001234);
            chk("stall_valid", 64'(out_valid), 64'd1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_ready", 64'(req_ready), 64'd2);
        step();
        req_valid = 2'b00;
        step();

        // Asynchronous reset while full drops the held result
        out_ready = 1'b0;
        issue(1, 16'h0055, 2'b00, 32'h00000055);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_id", 64'(out_id), 64'd0);
        void'(exp_data_q.pop_back());
        void'(exp_id_q.pop_back());
        req_imm0  = 16'h0007;
        req_mode0 = 2'b01;
        req_valid = 2'b11;
        @(negedge clk);
        chk("in_rst_ready", 64'(req_ready), 64'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_prio", 64'(req_ready), 64'd1);
        push(32'h00000007, 1'b0);
        step();
        req_valid = 2'b00;
        out_ready = 1'b1;
        step();

`ifdef IMM_EXT_STATS_EN
        // Counters: 3 port-0 transfers, 2 stall cycles, then saturation
        rst_n = 1'b0;
        #1;
        chk("stat_rst_gnt0", 64'(gnt_cnt0), 64'd0);
        chk("stat_rst_gnt1", 64'(gnt_cnt1), 64'd0);
        chk("stat_rst_stall", 64'(stall_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) issue(0, 16'h0010, 2'b00, 32'h00000010);
        out_ready = 1'b0;
        req_valid = 2'b01;
        step();
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("stat_gnt0_3", 64'(gnt_cnt0), 64'd3);
        chk("stat_stall_2", 64'(stall_cnt), 64'd2);
        push(32'h00000010, 1'b0);
        push(32'h00000010, 1'b0);
        step();
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("stat_gnt0_sat", 64'(gnt_cnt0), 64'd3);
        chk("stat_gnt1", 64'(gnt_cnt1), 64'd0);
        chk("stat_stall_hold", 64'(stall_cnt), 64'd2);
        step();
`endif

        step();
        chk("scoreboard_empty", 64'(exp_data_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
